vga_pattern_gen: RTL

Parametrised VGA timing and test-pattern engine. It generates horizontal and vertical sync, pixel coordinates and selectable RGB content: LFSR noise, colour bars, checkerboard or gradient. It sits directly behind the pixel clock generator and drives the board's VGA pins. It replaces the fixed sync-plus-noise arrangement used in the top level. Every output is registered, so sync, blanking and colour stay cycle-aligned at the pins.

---
 rtl/vga_pattern_gen.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA sync/timing generator with selectable test patterns
// (LFSR noise, colour bars, checkerboard, gradient). All outputs registered,
// one cycle after the counter state they describe.
// Optional build macro VGA_PATTERN_SCROLL_EN adds an 8-bit frame counter that
// scrolls the checkerboard and gradient one pixel per frame.
module vga_pattern_gen #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int          R_W      = 3,
  parameter int          G_W      = 3,
  parameter int          B_W      = 2,
  parameter logic [15:0] SEED_R   = 16'hACE1,
  parameter logic [15:0] SEED_G   = 16'h1D2B,
  parameter logic [15:0] SEED_B   = 16'h5A5A
) (
  input  logic           PIXEL_CLK,
  input  logic           RST_N,
  input  logic           EN,
  input  logic [1:0]     MODE,
  output logic [12:0]    locX,
  output logic [12:0]    locY,
  output logic           in_image,
  output logic           sync_h,
  output logic           sync_v,
  output logic           frame_start,
  output logic [R_W-1:0] vgaRed,
  output logic [G_W-1:0] vgaGreen,
  output logic [B_W-1:0] vgaBlue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [12:0] H_ACT_C  = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT_C  = 13'(V_ACTIVE);
  localparam logic [12:0] H_LAST_C = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_LAST_C = 13'(V_TOTAL - 1);
  localparam logic [12:0] HS_BEG_C = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END_C = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_BEG_C = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END_C = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] BAR_END_C = 13'(H_ACTIVE / 8 - 1);

  // Galois LFSR, x^16+x^14+x^13+x^11+1, shifting toward bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // bar index stops at the last bar so remainder pixels stay in bar 7
  function automatic logic [2:0] sat_inc3(input logic [2:0] x);
    return (x == 3'd7) ? x : x + 3'd1;
  endfunction

  logic [12:0]    h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, hx;
  logic [1:0]     mode_q, mode_d, mode_eff;
  logic [2:0]     bar_idx_q, bar_idx_d, bar_c;
  logic [12:0]    bar_px_q, bar_px_d;
  logic [15:0]    lfsr_r_q, lfsr_r_d, lfsr_g_q, lfsr_g_d, lfsr_b_q, lfsr_b_d;
  logic           h_last, v_last, frame_top, active, square;
  logic [12:0]    loc_x_q, loc_x_d, loc_y_q, loc_y_d;
  logic           in_image_q, in_image_d, sync_h_q, sync_h_d, sync_v_q, sync_v_d;
  logic           frame_start_q, frame_start_d;
  logic [R_W-1:0] red_q, red_d;
  logic [G_W-1:0] green_q, green_d;
  logic [B_W-1:0] blue_q, blue_d;
`ifdef VGA_PATTERN_SCROLL_EN
  logic [7:0]     frame_cnt_q, frame_cnt_d;
`endif

  // raster counters, frame-latched mode, bar tracking and LFSR advance
  always_comb begin
    h_last    = (h_cnt_q == H_LAST_C);
    v_last    = (v_cnt_q == V_LAST_C);
    h_cnt_d   = h_last ? 13'd0 : h_cnt_q + 13'd1;
    v_cnt_d   = v_cnt_q;
    if (h_last) v_cnt_d = v_last ? 13'd0 : v_cnt_q + 13'd1;
    frame_top = (h_cnt_q == 13'd0) && (v_cnt_q == 13'd0);
    // the first pixel of a frame already uses the freshly sampled mode
    mode_eff  = frame_top ? MODE : mode_q;
    mode_d    = mode_eff;
    bar_idx_d = bar_idx_q;
    bar_px_d  = bar_px_q;
    if (h_last) begin
      bar_idx_d = 3'd0;
      bar_px_d  = 13'd0;
    end else if (h_cnt_q < H_ACT_C) begin
      if (bar_px_q == BAR_END_C) begin
        bar_px_d  = 13'd0;
        bar_idx_d = sat_inc3(bar_idx_q);
      end else begin
        bar_px_d  = bar_px_q + 13'd1;
      end
    end
    lfsr_r_d = lfsr_next(lfsr_r_q);
    lfsr_g_d = lfsr_next(lfsr_g_q);
    lfsr_b_d = lfsr_next(lfsr_b_q);
`ifdef VGA_PATTERN_SCROLL_EN
    frame_cnt_d = (h_last && v_last) ? frame_cnt_q + 8'd1 : frame_cnt_q;
    hx          = h_cnt_q + {5'd0, frame_cnt_q};
`else
    hx          = h_cnt_q;
`endif
  end

  // pattern selection and next values of the registered outputs
  always_comb begin
    active   = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    bar_c    = 3'd7 - bar_idx_q;
    square   = hx[5] ^ v_cnt_q[5];
    red_d    = '0;
    green_d  = '0;
    blue_d   = '0;
    case (mode_eff)
      2'd0: begin
        red_d   = lfsr_r_q[R_W-1:0];
        green_d = lfsr_g_q[G_W-1:0];
        blue_d  = lfsr_b_q[B_W-1:0];
      end
      2'd1: begin
        red_d   = {R_W{bar_c[2]}};
        green_d = {G_W{bar_c[1]}};
        blue_d  = {B_W{bar_c[0]}};
      end
      2'd2: begin
        red_d   = {R_W{square}};
        green_d = {G_W{square}};
        blue_d  = {B_W{square}};
      end
      default: begin
        red_d   = R_W'(hx >> 5);
        green_d = G_W'(v_cnt_q >> 5);
        blue_d  = B_W'((hx + v_cnt_q) >> 6);
      end
    endcase
    if (!(active && EN)) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
    loc_x_d       = h_cnt_q;
    loc_y_d       = v_cnt_q;
    in_image_d    = active;
    sync_h_d      = ((h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C)) ? SYNC_POL : ~SYNC_POL;
    sync_v_d      = ((v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C)) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = frame_top;
  end

  // state and output registers; reset restarts the raster at (0,0)
  always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      mode_q        <= '0;
      bar_idx_q     <= '0;
      bar_px_q      <= '0;
      lfsr_r_q      <= SEED_R;
      lfsr_g_q      <= SEED_G;
      lfsr_b_q      <= SEED_B;
      loc_x_q       <= '0;
      loc_y_q       <= '0;
      in_image_q    <= 1'b0;
      sync_h_q      <= ~SYNC_POL;
      sync_v_q      <= ~SYNC_POL;
      frame_start_q <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
`ifdef VGA_PATTERN_SCROLL_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      mode_q        <= mode_d;
      bar_idx_q     <= bar_idx_d;
      bar_px_q      <= bar_px_d;
      lfsr_r_q      <= lfsr_r_d;
      lfsr_g_q      <= lfsr_g_d;
      lfsr_b_q      <= lfsr_b_d;
      loc_x_q       <= loc_x_d;
      loc_y_q       <= loc_y_d;
      in_image_q    <= in_image_d;
      sync_h_q      <= sync_h_d;
      sync_v_q      <= sync_v_d;
      frame_start_q <= frame_start_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
`ifdef VGA_PATTERN_SCROLL_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign locX        = loc_x_q;
  assign locY        = loc_y_q;
  assign in_image    = in_image_q;
  assign sync_h      = sync_h_q;
  assign sync_v      = sync_v_q;
  assign frame_start = frame_start_q;
  assign vgaRed      = red_q;
  assign vgaGreen    = green_q;
  assign vgaBlue     = blue_q;

endmodule
